// File: rtl/message_ctl_pkg.sv
// rtl/message_ctl_pkg.sv - shared types and sizing helpers for the message control serializer
package message_ctl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Symbols per frame: the last symbol is zero-padded when MSG_W is not a multiple of LANES.
  function automatic int calc_nsym(input int msg_w, input int lanes);
    return (msg_w + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/message_lane_mux.sv
// rtl/message_lane_mux.sv - picks the LANES bits of one symbol from the active message
module message_lane_mux #(
  parameter int MSG_W = 120,
  parameter int LANES = 2,
  parameter int NSYM  = 60,
  parameter int CNT_W = 6
) (
  input  logic [MSG_W-1:0] data_i,
  input  logic [CNT_W-1:0] sym_idx_i,
  input  logic [LANES-1:0] lane_en_i,
  output logic [LANES-1:0] bits_o
);

  // Zero-extending to a whole number of symbols makes the padding bits fall out as 0.
  localparam int PAD_W = NSYM * LANES;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(data_i);
  assign bits_o = LANES'(padded >> (32'(sym_idx_i) * LANES)) & lane_en_i;

endmodule

// File: rtl/message_ctl_serializer.sv
// rtl/message_ctl_serializer.sv - shadow-buffered message word serialised over LANES bits per cycle
module message_ctl_serializer
  import message_ctl_pkg::*;
#(
  parameter int MSG_W = 120,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_active,
  input  logic             frame_start,
  input  logic             mode_repeat,
  input  logic [LANES-1:0] lane_en,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [MSG_W-1:0] msg_data,
  output logic [LANES-1:0] sym_out,
  output logic             sym_valid,
  output logic             frame_done,
  output logic             underrun,
  output logic             overrun
);

  localparam int NSYM  = calc_nsym(MSG_W, LANES);
  localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSYM - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [MSG_W-1:0] active_q;
  logic [MSG_W-1:0] shadow_q;
  logic             shadow_full_q;
  logic             have_sent_q;

  logic [LANES-1:0] sym_out_q, sym_out_d;
  logic             sym_valid_q, sym_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;

  logic [LANES-1:0] lane_bits;
  logic             last_sym;
  logic             start_req;
  logic             start_acc;
  logic             data_avail;
  logic             start_go;
  logic             consume;
  logic             load;

  // A start is only accepted when idle or on the final symbol, which gives gapless frames.
  assign last_sym   = (state_q == ST_SEND) && (cnt_q == LAST_CNT);
  assign start_req  = frame_start && tx_active;
  assign start_acc  = start_req && ((state_q == ST_IDLE) || last_sym);
  assign data_avail = shadow_full_q || (mode_repeat && have_sent_q);
  assign start_go   = start_acc && data_avail;
  assign consume    = start_go && shadow_full_q;
  assign load       = msg_valid && msg_ready;
  assign msg_ready  = !shadow_full_q;

  message_lane_mux #(
    .MSG_W (MSG_W),
    .LANES (LANES),
    .NSYM  (NSYM),
    .CNT_W (CNT_W)
  ) u_lane_mux (
    .data_i    (active_q),
    .sym_idx_i (cnt_q),
    .lane_en_i (lane_en),
    .bits_o    (lane_bits)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: dropping tx_active aborts, the last symbol ends the frame unless restarted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_go) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_active) begin
          state_d = ST_IDLE;
        end else if (last_sym) begin
          state_d = start_go ? ST_SEND : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: the symbol at the current counter is presented after the next edge.
  always_comb begin
    sym_out_d    = '0;
    sym_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if ((state_q == ST_SEND) && tx_active) begin
      sym_out_d    = lane_bits;
      sym_valid_d  = 1'b1;
      frame_done_d = last_sym;
    end
    underrun_d = start_acc && !data_avail;
    overrun_d  = start_req && (state_q == ST_SEND) && !last_sym;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_out_q    <= '0;
      sym_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sym_out_q    <= sym_out_d;
      sym_valid_q  <= sym_valid_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

  // Buffers and symbol counter; a consume moves the shadow first, then a load may refill it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      have_sent_q   <= 1'b0;
    end else begin
      if (start_go) begin
        cnt_q <= '0;
      end else if ((state_q == ST_SEND) && tx_active && !last_sym) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
      if (consume) begin
        active_q      <= shadow_q;
        shadow_full_q <= 1'b0;
        have_sent_q   <= 1'b1;
      end
      if (load) begin
        shadow_q      <= msg_data;
        shadow_full_q <= 1'b1;
      end
    end
  end

  assign sym_out    = sym_out_q;
  assign sym_valid  = sym_valid_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_message_ctl_serializer.sv
// tb/tb_message_ctl_serializer.sv - directed vector bench for message_ctl_serializer
module tb_message_ctl_serializer;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic         clk;
  logic         rst_n;
  logic         tx_active;
  logic         mode_repeat;
  logic [1:0]   lane_en;

  logic         fs_b, mv_b, rdy_b, sv_b, fd_b, un_b, ov_b;
  logic [119:0] md_b;
  logic [1:0]   so_b;

  logic         fs_s, mv_s, rdy_s, sv_s, fd_s, un_s, ov_s;
  logic [4:0]   md_s;
  logic [1:0]   so_s;

  int n_vec;
  int n_miss;

  typedef struct {
    logic       tx;
    logic       fs;
    logic       rep;
    logic       mv;
    logic [4:0] data;
    logic [1:0] le;
    logic [1:0] e_sym;
    logic       e_val;
    logic       e_fd;
    logic       e_un;
    logic       e_ov;
    logic       e_rdy;
  } vec_t;

  vec_t vecs[21];

  message_ctl_serializer #(.MSG_W(120), .LANES(2)) u_big (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_active   (tx_active),
    .frame_start (fs_b),
    .mode_repeat (mode_repeat),
    .lane_en     (lane_en),
    .msg_valid   (mv_b),
    .msg_ready   (rdy_b),
    .msg_data    (md_b),
    .sym_out     (so_b),
    .sym_valid   (sv_b),
    .frame_done  (fd_b),
    .underrun    (un_b),
    .overrun     (ov_b)
  );

  message_ctl_serializer #(.MSG_W(5), .LANES(2)) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_active   (tx_active),
    .frame_start (fs_s),
    .mode_repeat (mode_repeat),
    .lane_en     (lane_en),
    .msg_valid   (mv_s),
    .msg_ready   (rdy_s),
    .msg_data    (md_s),
    .sym_out     (so_s),
    .sym_valid   (sv_s),
    .frame_done  (fd_s),
    .underrun    (un_s),
    .overrun     (ov_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start was sampled at the previous edge; observe 62 cycles of a 60-symbol frame.
  task automatic big_frame(input logic [1:0] s0, input logic [1:0] srest, input string tag);
    int seen;
    logic [1:0] es;
    seen = 0;
    check({tag, " no sym before T+1"}, {31'd0, sv_b}, 32'd0);
    for (int c = 1; c <= 62; c++) begin
      step();
      es = (c == 1) ? s0 : srest;
      if (c > 60) es = 2'b00;
      check($sformatf("%s c%0d valid", tag, c), {31'd0, sv_b}, (c <= 60) ? 32'd1 : 32'd0);
      check($sformatf("%s c%0d sym", tag, c), {30'd0, so_b}, {30'd0, es});
      check($sformatf("%s c%0d done", tag, c), {31'd0, fd_b}, (c == 60) ? 32'd1 : 32'd0);
      if (sv_b) seen++;
    end
    check({tag, " valid count"}, seen, 32'd60);
  endtask

  initial begin
    int seen;
    int guard;
    n_vec  = 0;
    n_miss = 0;

    //            tx fs rep mv data      le     sym    val fd un ov rdy
    vecs[0]  = '{H, L, L, H, 5'b10111, 2'b11, 2'b00, L, L, L, L, L};
    vecs[1]  = '{H, H, L, L, 5'b00000, 2'b11, 2'b00, L, L, L, L, H};
    vecs[2]  = '{H, L, L, L, 5'b00000, 2'b11, 2'b11, H, L, L, L, H};
    vecs[3]  = '{H, L, L, L, 5'b00000, 2'b11, 2'b01, H, L, L, L, H};
    vecs[4]  = '{H, L, L, L, 5'b00000, 2'b11, 2'b01, H, H, L, L, H};
    vecs[5]  = '{H, H, L, L, 5'b00000, 2'b11, 2'b00, L, L, H, L, H};
    vecs[6]  = '{H, L, L, L, 5'b00000, 2'b11, 2'b00, L, L, L, L, H};
    vecs[7]  = '{H, H, H, L, 5'b00000, 2'b11, 2'b00, L, L, L, L, H};
    vecs[8]  = '{H, L, H, L, 5'b00000, 2'b11, 2'b11, H, L, L, L, H};
    vecs[9]  = '{H, L, H, L, 5'b00000, 2'b11, 2'b01, H, L, L, L, H};
    vecs[10] = '{H, L, H, L, 5'b00000, 2'b11, 2'b01, H, H, L, L, H};
    vecs[11] = '{H, L, L, L, 5'b00000, 2'b11, 2'b00, L, L, L, L, H};
    vecs[12] = '{H, L, L, H, 5'b01010, 2'b11, 2'b00, L, L, L, L, L};
    vecs[13] = '{H, H, L, L, 5'b00000, 2'b11, 2'b00, L, L, L, L, H};
    vecs[14] = '{H, H, L, L, 5'b00000, 2'b11, 2'b10, H, L, L, H, H};
    vecs[15] = '{H, L, L, H, 5'b00100, 2'b11, 2'b10, H, L, L, L, L};
    vecs[16] = '{H, H, L, L, 5'b00000, 2'b11, 2'b00, H, H, L, L, H};
    vecs[17] = '{H, L, L, L, 5'b00000, 2'b11, 2'b00, H, L, L, L, H};
    vecs[18] = '{H, L, L, L, 5'b00000, 2'b11, 2'b01, H, L, L, L, H};
    vecs[19] = '{H, L, L, L, 5'b00000, 2'b11, 2'b00, H, H, L, L, H};
    vecs[20] = '{H, L, L, L, 5'b00000, 2'b11, 2'b00, L, L, L, L, H};

    rst_n       = 1'b0;
    tx_active   = 1'b1;
    mode_repeat = 1'b0;
    lane_en     = 2'b11;
    fs_b = 1'b0; mv_b = 1'b0; md_b = '0;
    fs_s = 1'b0; mv_s = 1'b0; md_s = '0;
    repeat (2) @(negedge clk);

    check("reset big valid", {31'd0, sv_b}, 32'd0);
    check("reset big sym", {30'd0, so_b}, 32'd0);
    check("reset big ready", {31'd0, rdy_b}, 32'd1);
    check("reset small ready", {31'd0, rdy_s}, 32'd1);
    check("reset small flags", {28'd0, sv_s, fd_s, un_s, ov_s}, 32'd0);
    rst_n = 1'b1;
    step();

    // Small instance: 5-bit message, padding, repeat, underrun, overrun, back-to-back.
    for (int i = 0; i < 21; i++) begin
      tx_active   = vecs[i].tx;
      fs_s        = vecs[i].fs;
      mode_repeat = vecs[i].rep;
      mv_s        = vecs[i].mv;
      md_s        = vecs[i].data;
      lane_en     = vecs[i].le;
      step();
      check($sformatf("row%0d sym", i), {30'd0, so_s}, {30'd0, vecs[i].e_sym});
      check($sformatf("row%0d valid", i), {31'd0, sv_s}, {31'd0, vecs[i].e_val});
      check($sformatf("row%0d done", i), {31'd0, fd_s}, {31'd0, vecs[i].e_fd});
      check($sformatf("row%0d underrun", i), {31'd0, un_s}, {31'd0, vecs[i].e_un});
      check($sformatf("row%0d overrun", i), {31'd0, ov_s}, {31'd0, vecs[i].e_ov});
      check($sformatf("row%0d ready", i), {31'd0, rdy_s}, {31'd0, vecs[i].e_rdy});
    end
    fs_s = 1'b0; mv_s = 1'b0; mode_repeat = 1'b0; lane_en = 2'b11;

    // Big instance: single set bit shows up only in symbol 0.
    mv_b = 1'b1; md_b = 120'h1;
    step();
    mv_b = 1'b0;
    check("big load ready", {31'd0, rdy_b}, 32'd0);
    fs_b = 1'b1;
    step();
    fs_b = 1'b0;
    big_frame(2'b01, 2'b00, "one");
    check("big ready after one", {31'd0, rdy_b}, 32'd1);

    // Abort at symbol 20 with a second message waiting in the shadow.
    mv_b = 1'b1; md_b = {60{2'b01}};
    step();
    mv_b = 1'b0;
    fs_b = 1'b1;
    step();
    fs_b = 1'b0;
    mv_b = 1'b1; md_b = {120{1'b1}};
    step();
    mv_b = 1'b0;
    seen = (sv_b) ? 1 : 0;
    check("abort shadow refilled", {31'd0, rdy_b}, 32'd0);
    guard = 0;
    while (seen < 21 && guard < 40) begin
      step();
      guard++;
      if (sv_b) begin
        check($sformatf("abort pre sym%0d", seen), {30'd0, so_b}, 32'd1);
        seen++;
      end
    end
    check("abort reached sym20", seen, 32'd21);
    tx_active = 1'b0;
    step();
    check("abort valid", {31'd0, sv_b}, 32'd0);
    check("abort sym", {30'd0, so_b}, 32'd0);
    check("abort done", {31'd0, fd_b}, 32'd0);
    check("abort shadow kept", {31'd0, rdy_b}, 32'd0);
    tx_active = 1'b1;
    step();
    step();
    check("abort idle", {31'd0, sv_b}, 32'd0);
    lane_en = 2'b10;
    fs_b = 1'b1;
    step();
    fs_b = 1'b0;
    big_frame(2'b10, 2'b10, "lane10");
    check("big ready after lane10", {31'd0, rdy_b}, 32'd1);
    lane_en = 2'b11;

    // Reset between edges in the middle of a repeat frame with a full shadow.
    mode_repeat = 1'b1;
    fs_b = 1'b1;
    step();
    fs_b = 1'b0;
    mv_b = 1'b1; md_b = 120'h5;
    step();
    mv_b = 1'b0;
    check("rst pre shadow full", {31'd0, rdy_b}, 32'd0);
    repeat (5) step();
    check("rst pre mid frame", {31'd0, sv_b}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst async valid", {31'd0, sv_b}, 32'd0);
    check("rst async sym", {30'd0, so_b}, 32'd0);
    check("rst async done", {31'd0, fd_b}, 32'd0);
    check("rst async ready", {31'd0, rdy_b}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mode_repeat = 1'b0;
    step();
    check("rst post idle", {31'd0, sv_b}, 32'd0);
    fs_b = 1'b1;
    step();
    fs_b = 1'b0;
    check("rst post underrun", {31'd0, un_b}, 32'd1);
    check("rst post no valid", {31'd0, sv_b}, 32'd0);
    step();
    check("rst post underrun clear", {31'd0, un_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/message_ctl_serializer.md
# message_ctl_serializer

Parametrised successor to the single-bit message control channel. Accepts a whole message word through a valid/ready handshake into a shadow buffer, then serialises it on `frame_start` as `LANES` bits per cycle over a configurable number of lanes, with one-shot or repeat mode. It sits between the message source and the TX symbol mapper, and is gated by `tx_active`.

## Interface
- `MSG_W`, 120: message width in bits, ≥1.
- `LANES`, 2: bits emitted per cycle, ≥1.
- `NSYM`, derived as ceil(`MSG_W`/`LANES`): symbols per frame; never overridden.
- `CNT_W`, derived as max(1, clog2(`NSYM`)): width of the symbol counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_active`  in  1  TX enable; low forces outputs to 0 and aborts any frame.
- `frame_start`  in  1  single-cycle request to start a frame.
- `mode_repeat`  in  1  1 means a frame may resend the last message when the shadow buffer is empty.
- `lane_en`  in  `LANES`  per-lane enable; a disabled lane outputs 0.
- `msg_valid`  in  1  a message is offered.
- `msg_ready`  out  1  equals !shadow_full (combinational).
- `msg_data`  in  `MSG_W`  message; bit 0 is sent first.
- `sym_out`  out  `LANES`  registered symbol; lane l carries bit (k·`LANES`+l) of symbol k.
- `sym_valid`  out  1  registered; high while `sym_out` carries frame data.
- `frame_done`  out  1  registered; high on the cycle the last symbol is presented.
- `underrun`  out  1  registered 1-cycle pulse: `frame_start` accepted with no data available.
- `overrun`  out  1  registered 1-cycle pulse: `frame_start` ignored because a frame is in progress.

## Operation
- Reset (asynchronous, `rst_n` low):
  - state returns to IDLE;
  - `shadow_full`, `have_sent`, the active buffer and the counter are cleared;
  - all registered outputs are 0, so `msg_ready` is 1.
- Load: when `msg_valid` && `msg_ready`, the shadow buffer takes `msg_data` and `shadow_full` is set. A new load is only possible once the shadow is consumed.
- State machine:
  - **IDLE → SEND** on a "start" when data is available. Data is available if `shadow_full` is set, or if `mode_repeat` && `have_sent`.
  - **SEND → IDLE** after symbol `NSYM`-1, unless a back-to-back start is accepted.
  - **SEND → IDLE** immediately when `tx_active` is low.
- Start: `frame_start` && `tx_active`, accepted when either:
  - state is IDLE; or
  - state is SEND and the counter is at `NSYM`-1 (gapless back-to-back frames).
- Start with `shadow_full` set:
  - the active buffer takes the shadow contents;
  - `shadow_full` is cleared;
  - `have_sent` is set.
- Start in repeat mode with an empty shadow: the active buffer is reused unchanged.
- Start with no data available: stay in or return to IDLE; pulse `underrun`.
- `frame_start` during SEND at any other counter value is ignored; pulse `overrun`.
- Load and consume in the same cycle: consume happens first, then the new message is written into the shadow, so the shadow ends full with the new message. `msg_ready` is still the pre-edge value.
- Symbol k: lane l = active[k·`LANES`+l] & `lane_en`[l]. Indices ≥ `MSG_W` output 0 (padding in the last symbol).
- `tx_active` low in any state:
  - `sym_out`, `sym_valid` and `frame_done` are 0 the next cycle;
  - the active frame is discarded;
  - the shadow buffer and `have_sent` are kept.
- `mode_repeat` and `lane_en` are sampled every cycle; a change mid-frame takes effect on the next symbol.

## Timing
- A start sampled at edge T puts symbol 0 on `sym_out` with `sym_valid` = 1 after edge T+1.
- Symbol k appears after edge T+1+k.
- `frame_done` coincides with symbol `NSYM`-1, after edge T+`NSYM`.
- Back-to-back: symbol 0 of the next frame directly follows the last symbol, with no gap cycle.
- `underrun` and `overrun` appear 1 cycle after the offending `frame_start`.
- `msg_ready` has zero latency from `shadow_full`.
- `NSYM` = 1: every accepted start produces a single cycle with `sym_valid` and `frame_done` both high.

## Structure
- Package `message_ctl_pkg`:
  - state enum (IDLE, SEND);
  - a function that computes `NSYM` from `MSG_W` and `LANES`.
- Sub-module `message_lane_mux`: combinational selection of `LANES` bits at the base index, with out-of-range bits forced to 0 and `lane_en` masking applied. The output register lives in the top module.

## Test plan
- Defaults (`MSG_W`=120, `LANES`=2):
  - load `msg_data`=120'h1 followed by all-zero bits 1-119, then pulse `frame_start`;
  - expect 60 cycles of `sym_valid`;
  - expect `sym_out`=2'b01 on symbol 0 and 2'b00 afterwards;
  - expect `frame_done` only on cycle 60.
- `MSG_W`=5, `LANES`=2, message 5'b10111:
  - expect symbols 2'b11, 2'b01, 2'b01, where the last symbol's lane 1 is padding;
  - expect `frame_done` on the 3rd symbol.
- Repeat and underrun: with `mode_repeat`=1, one loaded message and two starts, the same symbols are sent twice. With `mode_repeat`=0, the second start gives `underrun`=1 and no `sym_valid`.
- Back-to-back and overrun:
  - a second message loaded and `frame_start` at counter `NSYM`-1 gives gapless frames;
  - `frame_start` at counter 10 gives an `overrun` pulse and the frame continues unchanged.
- Abort: drop `tx_active` at symbol 20, then raise it again. Expect outputs 0 one cycle later, state IDLE, and the shadow message still full; a new start sends it.
- Reset mid-frame with `rst_n` low between clock edges: all outputs are 0 immediately and `msg_ready`=1. `lane_en`=2'b10 zeroes lane 0 on every symbol.
